// File: rtl/ii_pkg.sv
// rtl/ii_pkg.sv - shared integral-image constants, FSM states and corner tags
package ii_pkg;

    localparam int IMG_W  = 160;
    localparam int IMG_H  = 120;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Bit k set means corner k (A, B, C, D) is subtracted: +A -B -C +D
    localparam logic [3:0] CORNER_NEG = 4'b0110;

    // Per-read tag travelling alongside the buffer read latency
    typedef struct packed {
        logic valid;
        logic neg;
        logic zero;
    } tag_t;

endpackage

// File: rtl/ii_rect_sum_reader_if.sv
// rtl/ii_rect_sum_reader_if.sv - request, buffer port-B and response signals
interface ii_rect_sum_reader_if;
    import ii_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_x;
    logic [6:0]        req_y;
    logic [7:0]        req_w;
    logic [6:0]        req_h;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_sum;
    logic              rsp_err;

    // Reader side: accepts requests, drives port B, produces responses
    modport slave (
        input  req_valid, req_x, req_y, req_w, req_h, rd_data, rsp_ready,
        output req_ready, rd_en, rd_addr, rsp_valid, rsp_sum, rsp_err
    );

    // Requester / buffer side
    modport master (
        output req_valid, req_x, req_y, req_w, req_h, rd_data, rsp_ready,
        input  req_ready, rd_en, rd_addr, rsp_valid, rsp_sum, rsp_err
    );

endinterface

// File: rtl/ii_corner_addr.sv
// rtl/ii_corner_addr.sv - corner coordinate to buffer address with zero-corner flag
module ii_corner_addr
    import ii_pkg::*;
(
    input  logic signed [8:0]  cx,
    input  logic signed [7:0]  cy,
    output logic [ADDR_W-1:0]  addr,
    output logic               zero
);

    // A corner left of column 0 or above row 0 contributes nothing and reads address 0
    always_comb begin
        zero = cx[8] | cy[7];
        addr = '0;
        if (!zero) begin
            addr = ADDR_W'(cy[6:0]) * ADDR_W'(IMG_W) + ADDR_W'(cx[7:0]);
        end
    end

endmodule

// File: rtl/ii_rect_sum_reader.sv
// rtl/ii_rect_sum_reader.sv - fetches four integral-image corners and returns the rectangle sum
module ii_rect_sum_reader
    import ii_pkg::*;
#(
    parameter int RD_LAT = 1
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    ii_rect_sum_reader_if.slave  bus
);

    state_t                   state_q, state_d;
    logic [7:0]               x_q, x_d, w_q, w_d;
    logic [6:0]               y_q, y_d, h_q, h_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic signed [DATA_W:0]   acc_q, acc_d;
    tag_t [RD_LAT-1:0]        pipe_q, pipe_d;

    logic signed [8:0]        cx;
    logic signed [7:0]        cy;
    logic [ADDR_W-1:0]        caddr;
    logic                     czero;
    logic                     issue;
    logic                     in_bounds;
    tag_t                     ret;
    logic                     unused_acc_sign;

    assign issue           = (state_q == ISSUE);
    assign ret             = pipe_q[RD_LAT-1];
    assign unused_acc_sign = acc_q[DATA_W];

    // Corner index bit 0 picks the right edge, bit 1 the bottom edge: A, B, C, D
    always_comb begin
        cx = cnt_q[0] ? $signed({1'b0, x_q} + {1'b0, w_q} - 9'd1)
                      : $signed({1'b0, x_q} - 9'd1);
        cy = cnt_q[1] ? $signed({1'b0, y_q} + {1'b0, h_q} - 8'd1)
                      : $signed({1'b0, y_q} - 8'd1);
    end

    ii_corner_addr u_corner_addr (
        .cx   (cx),
        .cy   (cy),
        .addr (caddr),
        .zero (czero)
    );

    // Bounds check on the live request fields, used only in the accept cycle
    always_comb begin
        in_bounds = (bus.req_w != 8'd0) && (bus.req_h != 7'd0)
                 && ({1'b0, bus.req_x} + {1'b0, bus.req_w} <= 9'(IMG_W))
                 && ({1'b0, bus.req_y} + {1'b0, bus.req_h} <= 8'(IMG_H));
    end

    // Tag shift register, accumulation of returned words, and request FSM
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        acc_d   = acc_q;

        pipe_d[0].valid = issue;
        pipe_d[0].neg   = CORNER_NEG[cnt_q];
        pipe_d[0].zero  = czero;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (ret.valid && !ret.zero) begin
            acc_d = ret.neg ? acc_q - $signed({1'b0, bus.rd_data})
                            : acc_q + $signed({1'b0, bus.rd_data});
        end

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    x_d   = bus.req_x;
                    y_d   = bus.req_y;
                    w_d   = bus.req_w;
                    h_d   = bus.req_h;
                    cnt_d = 2'd0;
                    acc_d = '0;
                    err_d = !in_bounds;
                    state_d = in_bounds ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == 2'(RD_LAT - 1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any request and read data still in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            pipe_q  <= pipe_d;
        end
    end

    assign bus.req_ready = rst_n && (state_q == IDLE);
    assign bus.rd_en     = issue && !czero;
    assign bus.rd_addr   = issue ? caddr : '0;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_sum   = acc_q[DATA_W-1:0];
    assign bus.rsp_err   = err_q;

endmodule
